// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider:
// default operand width and FSM state encoding.
package div_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/FS.sv
// One-bit full subtractor: DIFF = A - B - BIN, BOUT is the borrow out.
module FS (
  input  logic A,
  input  logic B,
  input  logic BIN,
  output logic DIFF,
  output logic BOUT
);

  assign DIFF = A ^ B ^ BIN;
  assign BOUT = (~A & B) | (~(A ^ B) & BIN);

endmodule

// File: rtl/seq_divider8.sv
// Radix-2 restoring divider: one quotient bit per clock, trial subtraction
// through a ripple chain of full subtractors.
module seq_divider8
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             START,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIV_BY_ZERO
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_r;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH:0]   pr_s;
  logic [WIDTH:0]   dsr_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH:0]   bout_s;
  logic [WIDTH:0]   bin_s;
  logic             borrow_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] quo_next_s;
  logic             unused_diff_msb_s;

  // quo_r starts as the dividend; its MSB shifts into the partial remainder
  // while quotient bits fill in from the bottom.
  assign pr_s  = {rem_r, quo_r[WIDTH-1]};
  assign dsr_s = {1'b0, divisor_r};
  assign bin_s = {bout_s[WIDTH-1:0], 1'b0};

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fs
    FS u_fs (
      .A   (pr_s[i]),
      .B   (dsr_s[i]),
      .BIN (bin_s[i]),
      .DIFF(diff_s[i]),
      .BOUT(bout_s[i])
    );
  end

  // A successful trial always leaves a value below the divisor, so the
  // top difference bit carries no information.
  assign unused_diff_msb_s = diff_s[WIDTH];

  // Restore on borrow and form the next quotient bit.
  always_comb begin
    borrow_s   = bout_s[WIDTH];
    quo_next_s = {quo_r[WIDTH-2:0], ~borrow_s};
    if (borrow_s) begin
      rem_next_s = pr_s[WIDTH-1:0];
    end else begin
      rem_next_s = diff_s[WIDTH-1:0];
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      divisor_r   <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      quo_r       <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      QUOTIENT    <= {WIDTH{1'b0}};
      REMAINDER   <= {WIDTH{1'b0}};
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      DIV_BY_ZERO <= 1'b0;
    end else begin
      case (state_r)
        IDLE, FIN: begin
          if (START) begin
            divisor_r <= DIVISOR;
            rem_r     <= {WIDTH{1'b0}};
            quo_r     <= DIVIDEND;
            cnt_r     <= CW'(WIDTH);
            if (DIVISOR == {WIDTH{1'b0}}) begin
              state_r     <= FIN;
              QUOTIENT    <= {WIDTH{1'b1}};
              REMAINDER   <= DIVIDEND;
              DIV_BY_ZERO <= 1'b1;
              BUSY        <= 1'b0;
              DONE        <= 1'b1;
            end else begin
              state_r <= CALC;
              BUSY    <= 1'b1;
              DONE    <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
          end
        end
        CALC: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r     <= FIN;
            QUOTIENT    <= quo_next_s;
            REMAINDER   <= rem_next_s;
            DIV_BY_ZERO <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b1;
          end else begin
            state_r <= CALC;
            BUSY    <= 1'b1;
            DONE    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          BUSY    <= 1'b0;
          DONE    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider8.sv
// Self-checking bench for seq_divider8: directed scenarios plus randomized
// divisions checked against plain integer division.
module tb_seq_divider8;

  logic       clk;
  logic       rst;
  logic       START;
  logic [7:0] DIVIDEND;
  logic [7:0] DIVISOR;
  logic [7:0] QUOTIENT;
  logic [7:0] REMAINDER;
  logic       BUSY;
  logic       DONE;
  logic       DIV_BY_ZERO;

  int total = 0;
  int bad   = 0;

  seq_divider8 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .START      (START),
    .DIVIDEND   (DIVIDEND),
    .DIVISOR    (DIVISOR),
    .QUOTIENT   (QUOTIENT),
    .REMAINDER  (REMAINDER),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .DIV_BY_ZERO(DIV_BY_ZERO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Caller is at a negedge. Returns the edge count (START edge = 1) at which
  // DONE is seen, or -1 on timeout; leaves the bench at the DONE negedge.
  task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busy_n);
    DIVIDEND = a;
    DIVISOR  = b;
    START    = 1'b1;
    lat      = -1;
    busy_n   = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      START = 1'b0;
      if (BUSY) busy_n++;
      if (DONE) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({QUOTIENT, REMAINDER, BUSY, DONE, DIV_BY_ZERO} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%0h exp=0",
               {QUOTIENT, REMAINDER, BUSY, DONE, DIV_BY_ZERO});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, busy_n;
    do_div(8'd200, 8'd7, lat, busy_n);
    total++; if (lat !== 9) begin bad++; $display("FAIL basic_latency got=%0d exp=9", lat); end
    total++; if (busy_n !== 8) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=8", busy_n); end
    total++; if (QUOTIENT !== 8'd28) begin bad++; $display("FAIL basic_q got=%0d exp=28", QUOTIENT); end
    total++; if (REMAINDER !== 8'd4) begin bad++; $display("FAIL basic_r got=%0d exp=4", REMAINDER); end
    total++; if (DIV_BY_ZERO !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%0b exp=0", DIV_BY_ZERO); end
    @(negedge clk);
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%0b exp=0", DONE); end
    total++; if (QUOTIENT !== 8'd28) begin bad++; $display("FAIL basic_q_hold got=%0d exp=28", QUOTIENT); end
  endtask

  task automatic test_small();
    int lat, busy_n;
    do_div(8'd3, 8'd10, lat, busy_n);
    total++; if (lat !== 9) begin bad++; $display("FAIL small_latency got=%0d exp=9", lat); end
    total++; if (QUOTIENT !== 8'd0) begin bad++; $display("FAIL small_q got=%0d exp=0", QUOTIENT); end
    total++; if (REMAINDER !== 8'd3) begin bad++; $display("FAIL small_r got=%0d exp=3", REMAINDER); end
    @(negedge clk);
    do_div(8'd255, 8'd1, lat, busy_n);
    total++; if (QUOTIENT !== 8'd255) begin bad++; $display("FAIL max_q got=%0d exp=255", QUOTIENT); end
    total++; if (REMAINDER !== 8'd0) begin bad++; $display("FAIL max_r got=%0d exp=0", REMAINDER); end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    int lat, busy_n;
    do_div(8'd5, 8'd0, lat, busy_n);
    total++; if (lat !== 1) begin bad++; $display("FAIL dz_latency got=%0d exp=1", lat); end
    total++; if (busy_n !== 0) begin bad++; $display("FAIL dz_busy got=%0d exp=0", busy_n); end
    total++; if (QUOTIENT !== 8'hFF) begin bad++; $display("FAIL dz_q got=%0h exp=ff", QUOTIENT); end
    total++; if (REMAINDER !== 8'd5) begin bad++; $display("FAIL dz_r got=%0d exp=5", REMAINDER); end
    total++; if (DIV_BY_ZERO !== 1'b1) begin bad++; $display("FAIL dz_flag got=%0b exp=1", DIV_BY_ZERO); end
    @(negedge clk);
    total++; if ({DONE, DIV_BY_ZERO} !== 2'b01) begin bad++; $display("FAIL dz_hold got=%0b exp=01", {DONE, DIV_BY_ZERO}); end
    do_div(8'd9, 8'd3, lat, busy_n);
    total++; if (QUOTIENT !== 8'd3) begin bad++; $display("FAIL dz_clear_q got=%0d exp=3", QUOTIENT); end
    total++; if (DIV_BY_ZERO !== 1'b0) begin bad++; $display("FAIL dz_clear_flag got=%0b exp=0", DIV_BY_ZERO); end
    @(negedge clk);
  endtask

  task automatic test_start_during_calc();
    int dones, first;
    logic [7:0] q_at, r_at;
    dones = 0; first = -1; q_at = 8'd0; r_at = 8'd0;
    DIVIDEND = 8'd200; DIVISOR = 8'd7; START = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      @(negedge clk);
      START = 1'b0;
      if (k == 3) begin
        DIVIDEND = 8'd50; DIVISOR = 8'd3; START = 1'b1;
      end
      if (DONE) begin
        dones++;
        if (first < 0) begin first = k; q_at = QUOTIENT; r_at = REMAINDER; end
      end
    end
    total++; if (dones !== 1) begin bad++; $display("FAIL calc_start_dones got=%0d exp=1", dones); end
    total++; if (first !== 9) begin bad++; $display("FAIL calc_start_latency got=%0d exp=9", first); end
    total++; if (q_at !== 8'd28) begin bad++; $display("FAIL calc_start_q got=%0d exp=28", q_at); end
    total++; if (r_at !== 8'd4) begin bad++; $display("FAIL calc_start_r got=%0d exp=4", r_at); end
  endtask

  task automatic test_reset_mid_calc();
    int lat, busy_n, dones;
    dones = 0;
    DIVIDEND = 8'd200; DIVISOR = 8'd7; START = 1'b1;
    @(posedge clk);
    @(negedge clk);
    START = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL rstcalc_busy_before got=%0b exp=1", BUSY); end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({QUOTIENT, REMAINDER, BUSY, DONE, DIV_BY_ZERO} !== 19'd0) begin
      bad++;
      $display("FAIL rstcalc_outputs got=%0h exp=0",
               {QUOTIENT, REMAINDER, BUSY, DONE, DIV_BY_ZERO});
    end
    repeat (2) begin
      @(negedge clk);
      if (DONE) dones++;
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (DONE) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL rstcalc_no_done got=%0d exp=0", dones); end
    do_div(8'd77, 8'd5, lat, busy_n);
    total++; if (lat !== 9) begin bad++; $display("FAIL rstcalc_after_latency got=%0d exp=9", lat); end
    total++; if (QUOTIENT !== 8'd15) begin bad++; $display("FAIL rstcalc_after_q got=%0d exp=15", QUOTIENT); end
    total++; if (REMAINDER !== 8'd2) begin bad++; $display("FAIL rstcalc_after_r got=%0d exp=2", REMAINDER); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, busy_n;
    do_div(8'd200, 8'd7, lat, busy_n);
    total++; if (QUOTIENT !== 8'd28) begin bad++; $display("FAIL b2b_first_q got=%0d exp=28", QUOTIENT); end
    do_div(8'd100, 8'd9, lat, busy_n);
    total++; if (lat !== 9) begin bad++; $display("FAIL b2b_latency got=%0d exp=9", lat); end
    total++; if (busy_n !== 8) begin bad++; $display("FAIL b2b_busy got=%0d exp=8", busy_n); end
    total++; if (QUOTIENT !== 8'd11) begin bad++; $display("FAIL b2b_q got=%0d exp=11", QUOTIENT); end
    total++; if (REMAINDER !== 8'd1) begin bad++; $display("FAIL b2b_r got=%0d exp=1", REMAINDER); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, busy_n, elat;
    logic [7:0] a, b, eq, er;
    logic ez;
    for (int n = 0; n < 60; n++) begin
      a = 8'($urandom_range(0, 255));
      b = (n % 10 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (b == 8'd0) begin
        eq = 8'hFF; er = a; ez = 1'b1; elat = 1;
      end else begin
        eq = a / b; er = a % b; ez = 1'b0; elat = 9;
      end
      do_div(a, b, lat, busy_n);
      total++; if (lat !== elat) begin bad++; $display("FAIL rand_latency a=%0d b=%0d got=%0d exp=%0d", a, b, lat, elat); end
      total++; if (QUOTIENT !== eq) begin bad++; $display("FAIL rand_q a=%0d b=%0d got=%0d exp=%0d", a, b, QUOTIENT, eq); end
      total++; if (REMAINDER !== er) begin bad++; $display("FAIL rand_r a=%0d b=%0d got=%0d exp=%0d", a, b, REMAINDER, er); end
      total++; if (DIV_BY_ZERO !== ez) begin bad++; $display("FAIL rand_dbz a=%0d b=%0d got=%0b exp=%0b", a, b, DIV_BY_ZERO, ez); end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    START = 1'b0;
    DIVIDEND = 8'd0;
    DIVISOR = 8'd0;
    test_reset();
    test_basic();
    test_small();
    test_div_zero();
    test_start_during_calc();
    test_reset_mid_calc();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
